uart_alu_host: RTL

UART_ALU_HOST -- requirements
Module: uart_alu_host

---
 rtl/uart_alu_host.sv | 189 ++++++++++++++++++
 1 files changed

// File: rtl/uart_alu_host.sv
// UART ALU host: frames an opcode plus 32-bit operands into a byte packet, then
// collects a 4-byte little-endian result. Optional RESP timeout: UART_ALU_HOST_TIMEOUT_EN.
module uart_alu_host #(
    parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        cmd_valid_i,
    output logic        cmd_ready_o,
    input  logic [7:0]  cmd_opcode_i,
    input  logic [7:0]  cmd_count_i,
    input  logic [31:0] op_data_i,
    input  logic        op_valid_i,
    output logic        op_ready_o,
    output logic [7:0]  tx_data_o,
    output logic        tx_valid_o,
    input  logic        tx_ready_i,
    input  logic [7:0]  rx_data_i,
    input  logic        rx_valid_i,
    output logic        rx_ready_o,
    output logic [31:0] res_data_o,
    output logic        res_valid_o,
    input  logic        res_ready_i,
    output logic        res_err_o,
    output logic [2:0]  dbg_state_o
);
    // All streams: a transfer happens on a rising edge where valid and ready are
    // both 1; a source holds valid and data unchanged until that transfer.

    typedef enum logic [2:0] {S_IDLE, S_HDR, S_OPND, S_RESP, S_DONE} state_t;

    state_t      r_state, w_state_next;
    logic [7:0]  r_opcode;
    logic [7:0]  r_count;
    logic [1:0]  r_idx;
    logic [7:0]  r_opnd_cnt;
    logic [31:0] r_word;
    logic        r_held;
    logic [31:0] r_res;

    logic        w_cmd_hs, w_tx_hs, w_rx_hs;
    logic        w_last_word, w_timeout;
    logic [15:0] w_len;
    logic [7:0]  w_hdr_byte, w_opnd_byte;
    logic [31:0] w_word_src;

    assign w_cmd_hs    = cmd_valid_i & cmd_ready_o;
    assign w_tx_hs     = tx_valid_o & tx_ready_i;
    assign w_rx_hs     = rx_valid_i & rx_ready_o;
    assign w_len       = {6'd0, r_count, 2'b00} + 16'd4;
    assign w_last_word = (r_opnd_cnt == r_count - 8'd1);
    assign dbg_state_o = r_state;

    always_comb begin
        w_hdr_byte = r_opcode;
        case (r_idx)
            2'd0:    w_hdr_byte = r_opcode;
            2'd1:    w_hdr_byte = 8'h00;
            2'd2:    w_hdr_byte = w_len[7:0];
            default: w_hdr_byte = w_len[15:8];
        endcase
    end

    // Byte 0 of a fresh word is forwarded straight from op_data_i so that
    // header->operand and operand->operand boundaries need no idle cycle.
    assign w_word_src  = r_held ? r_word : op_data_i;
    assign w_opnd_byte = w_word_src[{r_idx, 3'b000} +: 8];

`ifdef UART_ALU_HOST_TIMEOUT_EN
    localparam int unsigned TO_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TO_W-1:0] r_to_cnt;
    logic            r_err;

    assign w_timeout = (r_state == S_RESP) && !w_rx_hs &&
                       (r_to_cnt == TO_W'(TIMEOUT_CYCLES - 1));
    assign res_err_o = r_err;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_to_cnt <= '0;
            r_err    <= 1'b0;
        end else begin
            if (r_state != S_RESP || w_rx_hs) r_to_cnt <= '0;
            else                              r_to_cnt <= r_to_cnt + 1'b1;
            if (w_cmd_hs)       r_err <= 1'b0;
            else if (w_timeout) r_err <= 1'b1;
        end
    end
`else
    logic w_unused_timeout;
    assign w_unused_timeout = (TIMEOUT_CYCLES == 0);
    assign w_timeout        = 1'b0;
    assign res_err_o        = 1'b0;
`endif

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) r_state <= S_IDLE;
        else         r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: if (w_cmd_hs) w_state_next = S_HDR;
            S_HDR:  if (w_tx_hs && r_idx == 2'd3)
                        w_state_next = (r_count != 8'd0) ? S_OPND : S_RESP;
            S_OPND: if (w_tx_hs && r_held && r_idx == 2'd3 && w_last_word)
                        w_state_next = S_RESP;
            S_RESP: if ((w_rx_hs && r_idx == 2'd3) || w_timeout)
                        w_state_next = S_DONE;
            S_DONE: if (res_ready_i) w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    always_comb begin
        cmd_ready_o = 1'b0;
        op_ready_o  = 1'b0;
        tx_valid_o  = 1'b0;
        tx_data_o   = 8'h00;
        rx_ready_o  = 1'b0;
        res_valid_o = 1'b0;
        case (r_state)
            S_IDLE: cmd_ready_o = 1'b1;
            S_HDR: begin
                tx_valid_o = 1'b1;
                tx_data_o  = w_hdr_byte;
            end
            S_OPND: begin
                op_ready_o = !r_held;
                tx_valid_o = r_held | op_valid_i;
                tx_data_o  = (r_held | op_valid_i) ? w_opnd_byte : 8'h00;
            end
            S_RESP: rx_ready_o  = 1'b1;
            S_DONE: res_valid_o = 1'b1;
            default: ;
        endcase
    end

    assign res_data_o = r_res;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_opcode   <= 8'h00;
            r_count    <= 8'h00;
            r_idx      <= 2'd0;
            r_opnd_cnt <= 8'h00;
            r_word     <= 32'h0;
            r_held     <= 1'b0;
            r_res      <= 32'h0;
        end else begin
            case (r_state)
                S_IDLE: if (w_cmd_hs) begin
                    r_opcode   <= cmd_opcode_i;
                    r_count    <= cmd_count_i;
                    r_idx      <= 2'd0;
                    r_opnd_cnt <= 8'h00;
                    r_held     <= 1'b0;
                end
                S_HDR: if (w_tx_hs) r_idx <= r_idx + 2'd1;
                S_OPND: begin
                    if (!r_held) begin
                        if (op_valid_i) begin
                            r_word <= op_data_i;
                            r_held <= 1'b1;
                            if (tx_ready_i) r_idx <= 2'd1;
                        end
                    end else if (tx_ready_i) begin
                        r_idx <= r_idx + 2'd1;
                        if (r_idx == 2'd3) begin
                            r_held     <= 1'b0;
                            r_opnd_cnt <= r_opnd_cnt + 8'd1;
                        end
                    end
                end
                S_RESP: begin
                    if (w_rx_hs) begin
                        r_res <= {rx_data_i, r_res[31:8]};
                        r_idx <= r_idx + 2'd1;
                    end else if (w_timeout) begin
                        r_res <= 32'h0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
